// File: rtl/pwm_pkg.sv
// Shared constants for the PWM waveform engine: counter width, mode and direction encodings.
package pwm_pkg;
    localparam int   PWM_WIDTH   = 16;
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;
    localparam logic DIR_UP      = 1'b0;
    localparam logic DIR_DOWN    = 1'b1;
endpackage

// File: rtl/pwm_deadtime.sv
// Complementary gate driver with deadtime insertion for one PWM channel.
// Off-side follows a reference edge after 1 clk; on-side follows after 1+dt_val clks.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic             i_ref,
    input  logic             i_dt_en,
    input  logic [WIDTH-1:0] i_dt_val,
    output logic             o_out_h,
    output logic             o_out_l
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             r_ref_d;
    logic [WIDTH-1:0] r_cnt;
    logic             w_edge;
    logic             w_dt_on;

    assign w_edge  = i_ref ^ r_ref_d;
    assign w_dt_on = i_dt_en && (i_dt_val != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ref_d <= 1'b0;
            r_cnt   <= '0;
            o_out_h <= 1'b0;
            o_out_l <= 1'b0;
        end else if (!i_run) begin
            r_ref_d <= 1'b0;
            r_cnt   <= '0;
            o_out_h <= 1'b0;
            o_out_l <= 1'b0;
        end else begin
            r_ref_d <= i_ref;
            if (!w_dt_on) begin
                r_cnt   <= '0;
                o_out_h <= i_ref;
                o_out_l <= ~i_ref;
            end else if (w_edge) begin
                // Any edge, including one that lands inside deadtime, restarts the gap.
                r_cnt   <= i_dt_val;
                o_out_h <= 1'b0;
                o_out_l <= 1'b0;
            end else if (r_cnt > ONE) begin
                r_cnt   <= r_cnt - ONE;
                o_out_h <= 1'b0;
                o_out_l <= 1'b0;
            end else begin
                r_cnt   <= '0;
                o_out_h <= i_ref;
                o_out_l <= ~i_ref;
            end
        end
    end
endmodule

// File: rtl/pwm_core.sv
// Prescaled edge/center-aligned PWM timer with shadowed config and two deadtime channel pairs.
// Config loads on enable and on each update event; gate outputs lag the counter by one clk.
module pwm_core
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty1,
    input  logic [WIDTH-1:0] duty2,
    input  logic [WIDTH-1:0] prescaler_div,
    input  logic [WIDTH-1:0] deadtime_val,
    input  logic [WIDTH-1:0] delay1,
    input  logic [WIDTH-1:0] delay2,
    input  logic             deadtime_en,
    output logic             pwm1_h,
    output logic             pwm1_l,
    output logic             pwm2_h,
    output logic             pwm2_l,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             update_evt
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             r_run;
    logic [WIDTH-1:0] r_psc;
    logic [WIDTH-1:0] r_cnt;
    logic             r_dir;
    logic             r_upd;

    logic             r_sh_mode;
    logic [WIDTH-1:0] r_sh_period;
    logic [WIDTH-1:0] r_sh_duty1;
    logic [WIDTH-1:0] r_sh_duty2;
    logic [WIDTH-1:0] r_sh_delay1;
    logic [WIDTH-1:0] r_sh_delay2;
    logic [WIDTH-1:0] r_sh_psc;
    logic             r_sh_dt_en;
    logic [WIDTH-1:0] r_sh_dt_val;

    logic             w_tick;
    logic             w_wrap;
    logic             w_load;
    logic             w_dt_run;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_dir_nxt;
    logic [WIDTH:0]   w_cnt_x;
    logic             w_ref1;
    logic             w_ref2;

    assign w_tick   = (r_psc == r_sh_psc);
    assign w_load   = en && (!r_run || w_wrap);
    assign w_dt_run = r_run && en;

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_dir_nxt = r_dir;
        w_wrap    = 1'b0;
        if (w_tick) begin
            if (r_sh_mode == MODE_EDGE) begin
                w_dir_nxt = DIR_UP;
                if (r_cnt >= r_sh_period) begin
                    w_cnt_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end else if (r_dir == DIR_UP) begin
                if (r_cnt >= r_sh_period) begin
                    // P of 0 or 1 has no down slope: the peak step is itself the wrap.
                    if (r_sh_period <= ONE) begin
                        w_cnt_nxt = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_cnt_nxt = r_sh_period - ONE;
                        w_dir_nxt = DIR_DOWN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end else begin
                if (r_cnt <= ONE) begin
                    w_cnt_nxt = '0;
                    w_dir_nxt = DIR_UP;
                    w_wrap    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run <= 1'b0;
            r_psc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
            r_upd <= 1'b0;
        end else if (!en) begin
            r_run <= 1'b0;
            r_psc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
            r_upd <= 1'b0;
        end else if (!r_run) begin
            r_run <= 1'b1;
            r_psc <= '0;
            r_cnt <= '0;
            r_dir <= DIR_UP;
            r_upd <= 1'b0;
        end else begin
            r_psc <= w_tick ? '0 : r_psc + ONE;
            r_cnt <= w_cnt_nxt;
            r_dir <= w_dir_nxt;
            r_upd <= w_wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_mode   <= MODE_EDGE;
            r_sh_period <= '0;
            r_sh_duty1  <= '0;
            r_sh_duty2  <= '0;
            r_sh_delay1 <= '0;
            r_sh_delay2 <= '0;
            r_sh_psc    <= '0;
            r_sh_dt_en  <= 1'b0;
            r_sh_dt_val <= '0;
        end else if (w_load) begin
            r_sh_mode   <= mode;
            r_sh_period <= period;
            r_sh_duty1  <= duty1;
            r_sh_duty2  <= duty2;
            r_sh_delay1 <= delay1;
            r_sh_delay2 <= delay2;
            r_sh_psc    <= prescaler_div;
            r_sh_dt_en  <= deadtime_en;
            r_sh_dt_val <= deadtime_val;
        end
    end

    // Compares carry one extra bit so delay + duty never wraps.
    assign w_cnt_x = {1'b0, r_cnt};
    assign w_ref1  = (r_sh_mode == MODE_CENTER) ? (r_cnt < r_sh_duty1)
                   : ((w_cnt_x >= {1'b0, r_sh_delay1}) &&
                      (w_cnt_x < ({1'b0, r_sh_delay1} + {1'b0, r_sh_duty1})));
    assign w_ref2  = (r_sh_mode == MODE_CENTER) ? (r_cnt < r_sh_duty2)
                   : ((w_cnt_x >= {1'b0, r_sh_delay2}) &&
                      (w_cnt_x < ({1'b0, r_sh_delay2} + {1'b0, r_sh_duty2})));

    pwm_deadtime #(.WIDTH(WIDTH)) u_dt1 (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_dt_run),
        .i_ref    (w_ref1),
        .i_dt_en  (r_sh_dt_en),
        .i_dt_val (r_sh_dt_val),
        .o_out_h  (pwm1_h),
        .o_out_l  (pwm1_l)
    );

    pwm_deadtime #(.WIDTH(WIDTH)) u_dt2 (
        .clk      (clk),
        .rst      (rst),
        .i_run    (w_dt_run),
        .i_ref    (w_ref2),
        .i_dt_en  (r_sh_dt_en),
        .i_dt_val (r_sh_dt_val),
        .o_out_h  (pwm2_h),
        .o_out_l  (pwm2_l)
    );

    assign cnt        = r_cnt;
    assign dir        = r_dir;
    assign update_evt = r_upd;
endmodule

// File: tb/tb_pwm_core.sv
// Directed bench for pwm_core: edge/center counting, prescaler, deadtime, shadowing, stop and reset.
module tb_pwm_core;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic [W-1:0] period, duty1, duty2, prescaler_div, deadtime_val, delay1, delay2;
    logic         deadtime_en;
    logic         pwm1_h, pwm1_l, pwm2_h, pwm2_l;
    logic [W-1:0] cnt;
    logic         dir;
    logic         update_evt;

    int n_vec = 0;
    int n_err = 0;
    int k, pk, dur;
    logic eh, el;
    int cs [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
    int ds [8] = '{0, 0, 0, 0, 0, 1, 1, 1};

    always #5 clk = ~clk;

    pwm_core #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .mode          (mode),
        .period        (period),
        .duty1         (duty1),
        .duty2         (duty2),
        .prescaler_div (prescaler_div),
        .deadtime_val  (deadtime_val),
        .delay1        (delay1),
        .delay2        (delay2),
        .deadtime_en   (deadtime_en),
        .pwm1_h        (pwm1_h),
        .pwm1_l        (pwm1_l),
        .pwm2_h        (pwm2_h),
        .pwm2_l        (pwm2_l),
        .cnt           (cnt),
        .dir           (dir),
        .update_evt    (update_evt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic m, input int p, input int d1, input int u1, input int u2,
                       input int ps, input logic dte, input int dtv);
        mode          = m;
        period        = W'(p);
        delay1        = W'(d1);
        duty1         = W'(u1);
        delay2        = '0;
        duty2         = W'(u2);
        prescaler_div = W'(ps);
        deadtime_en   = dte;
        deadtime_val  = W'(dtv);
    endtask

    // Stop, then enable; returns in the first cycle after the enabling edge (cnt = 0).
    task automatic start();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cfg(1'b0, 0, 0, 0, 0, 0, 1'b0, 0);
        step();
        step();
        check("rst_cnt", cnt, 0);
        check("rst_dir", dir, 0);
        check("rst_upd", update_evt, 0);
        check("rst_outs", {pwm1_h, pwm1_l, pwm2_h, pwm2_l}, 0);
        rst = 1'b0;
        step();
        check("idle_outs", {pwm1_h, pwm1_l, pwm2_h, pwm2_l}, 0);

        // Edge mode, P=9, delay1=2, duty1=3
        cfg(1'b0, 9, 2, 3, 0, 0, 1'b0, 0);
        start();
        check("e_c0_outs", {pwm1_h, pwm1_l}, 0);
        for (int j = 0; j <= 20; j++) begin
            k = j % 10;
            check($sformatf("e_cnt%0d", j), cnt, k);
            check($sformatf("e_upd%0d", j), update_evt, (j > 0 && k == 0));
            check($sformatf("e_dir%0d", j), dir, 0);
            if (j >= 1) begin
                pk = (j - 1) % 10;
                eh = (pk >= 2 && pk <= 4);
                check($sformatf("e_h%0d", j), pwm1_h, eh);
                check($sformatf("e_l%0d", j), pwm1_l, !eh);
            end
            step();
        end

        // Prescaler 3, P=4
        cfg(1'b0, 4, 2, 3, 0, 3, 1'b0, 0);
        start();
        for (int j = 0; j <= 40; j++) begin
            check($sformatf("p_cnt%0d", j), cnt, (j / 4) % 5);
            check($sformatf("p_upd%0d", j), update_evt, (j > 0 && j % 20 == 0));
            step();
        end

        // Center mode, P=4, duty2=2
        cfg(1'b1, 4, 0, 0, 2, 0, 1'b0, 0);
        start();
        for (int j = 0; j <= 17; j++) begin
            check($sformatf("c_cnt%0d", j), cnt, cs[j % 8]);
            check($sformatf("c_dir%0d", j), dir, ds[j % 8]);
            check($sformatf("c_upd%0d", j), update_evt, (j > 0 && j % 8 == 0));
            if (j >= 1) begin
                eh = (cs[(j - 1) % 8] < 2);
                check($sformatf("c_h%0d", j), pwm2_h, eh);
                check($sformatf("c_l%0d", j), pwm2_l, !eh);
            end
            step();
        end

        // Deadtime 3, P=15, ref1 high for cnt 2..7
        cfg(1'b0, 15, 2, 6, 0, 0, 1'b1, 3);
        start();
        check("d_c0_outs", {pwm1_h, pwm1_l}, 0);
        step();
        for (int j = 1; j <= 31; j++) begin
            k  = j % 16;
            eh = (k >= 6 && k <= 8);
            el = (k >= 12 || k <= 2);
            check($sformatf("d_h%0d", j), pwm1_h, eh);
            check($sformatf("d_l%0d", j), pwm1_l, el);
            check($sformatf("d_excl%0d", j), pwm1_h & pwm1_l, 0);
            step();
        end

        // Shadowing: duty1 3 -> 6 written mid-period
        cfg(1'b0, 9, 2, 3, 0, 0, 1'b0, 0);
        start();
        for (int j = 0; j <= 21; j++) begin
            if (j >= 1) begin
                pk  = (j - 1) % 10;
                dur = (j - 1 >= 10) ? 6 : 3;
                eh  = (pk >= 2 && pk < 2 + dur);
                check($sformatf("s_h%0d", j), pwm1_h, eh);
            end
            check($sformatf("s_upd%0d", j), update_evt, (j == 10 || j == 20));
            if (j == 5) duty1 = W'(6);
            step();
        end

        // Stop mid-pulse
        cfg(1'b0, 9, 2, 3, 0, 0, 1'b0, 0);
        start();
        for (int j = 0; j < 4; j++) step();
        check("stop_pre_h", pwm1_h, 1);
        check("stop_pre_cnt", cnt, 4);
        en = 1'b0;
        step();
        check("stop_cnt", cnt, 0);
        check("stop_outs", {pwm1_h, pwm1_l, pwm2_h, pwm2_l}, 0);
        check("stop_upd", update_evt, 0);
        check("stop_dir", dir, 0);
        step();
        check("stop_hold_cnt", cnt, 0);
        en = 1'b1;
        step();
        check("reen_cnt0", cnt, 0);
        check("reen_upd0", update_evt, 0);
        for (int j = 1; j <= 10; j++) begin
            step();
            check($sformatf("reen_cnt%0d", j), cnt, j % 10);
            check($sformatf("reen_upd%0d", j), update_evt, (j == 10));
        end

        // Async reset in the middle of deadtime
        cfg(1'b0, 15, 2, 6, 0, 0, 1'b1, 3);
        start();
        for (int j = 0; j < 4; j++) step();
        check("rdt_pre_cnt", cnt, 4);
        check("rdt_pre_outs", {pwm1_h, pwm1_l}, 0);
        #1;
        rst = 1'b1;
        #1;
        check("rdt_async_cnt", cnt, 0);
        check("rdt_async_outs", {pwm1_h, pwm1_l, pwm2_h, pwm2_l}, 0);
        check("rdt_async_upd", update_evt, 0);
        step();
        check("rdt_hold_outs", {pwm1_h, pwm1_l, pwm2_h, pwm2_l}, 0);
        rst = 1'b0;
        step();
        check("rdt_re_cnt0", cnt, 0);
        check("rdt_re_upd0", update_evt, 0);
        step();
        check("rdt_re_cnt1", cnt, 1);
        check("rdt_re_l1", pwm1_l, 1);
        check("rdt_re_upd1", update_evt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
